// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and line-level constants for the sipo framing receiver
//
// Purpose : FSM state encoding and the serial line levels used by sipo_framer.
// Ports   : none (package).

package sipo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/sipo_hold.sv
// rtl/sipo_hold.sv - output holding register with valid/ready handshake and overrun detection
//
// Purpose : Captures a good frame from the framer and keeps it until the consumer
//           accepts it. A good frame arriving while the register is still occupied
//           (and not being consumed on the same edge) is dropped and flagged.
// Ports   : clk, clear_n     - clock, async active-low reset
//           load, din        - good-frame strobe and word from the framer
//           dout_ready       - consumer accept
//           dout, dout_valid - held word and its valid flag
//           overrun          - one-cycle pulse, good frame lost

module sipo_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);

  // Consuming and loading on the same edge is allowed, so the register counts
  // as free while it is being handed off.
  logic free;
  assign free = !dout_valid || dout_ready;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load && free) begin
        dout       <= din;
        dout_valid <= 1'b1;
      end else if (load) begin
        overrun <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sipo_framer.sv
// rtl/sipo_framer.sv - serial-to-parallel framing receiver (start, LSB-first data, opt. parity, stop)
//
// Purpose : Detects a start bit on si, shifts in WIDTH data bits LSB first, checks
//           the stop bit (and even parity when SIPO_PARITY_EN is defined) and hands
//           good words to the holding register. Bad frames are dropped and reported.
// Macro   : SIPO_PARITY_EN - adds the parity bit and the live parity_err output.
// Ports   : clk, clear_n     - clock, async active-low reset
//           si               - serial line, idles high, one bit per clock
//           dout, dout_valid - received word and holding-register-full flag
//           dout_ready       - consumer accept
//           frame_err        - one-cycle pulse, stop bit sampled low
//           parity_err       - one-cycle pulse, parity mismatch (0 without the macro)
//           overrun          - one-cycle pulse, good frame lost to an occupied register

module sipo_framer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             si,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  import sipo_pkg::*;

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic             load;
  logic             stop_bad;
  logic             par_fail;

`ifdef SIPO_PARITY_EN
  logic par_bad_q;
  logic parity_err_q;
`endif

  // State register
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (si == START_LVL) state_d = ST_DATA;
      ST_DATA: begin
        if (cnt_q == LAST) begin
`ifdef SIPO_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode: stop-bit verdict. A bad stop bit hides any parity failure.
  always_comb begin
    load     = 1'b0;
    stop_bad = 1'b0;
    par_fail = 1'b0;
    if (state_q == ST_STOP) begin
      if (si != STOP_LVL) begin
        stop_bad = 1'b1;
`ifdef SIPO_PARITY_EN
      end else if (par_bad_q) begin
        par_fail = 1'b1;
`endif
      end else begin
        load = 1'b1;
      end
    end
  end

  // Counter, shift register and error pulse registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt_q        <= '0;
      shift_q      <= '0;
      frame_err    <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err <= stop_bad;
`ifdef SIPO_PARITY_EN
      parity_err_q <= par_fail;
`endif
      case (state_q)
        ST_IDLE: begin
          if (si == START_LVL) cnt_q <= '0;
        end
        ST_DATA: begin
          shift_q[cnt_q] <= si;
          // Counter parks at LAST; IDLE clears it for the next frame.
          if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
        end
`ifdef SIPO_PARITY_EN
        ST_PARITY: begin
          // Even parity: data bits XOR parity bit must be 0.
          par_bad_q <= (^shift_q) ^ si;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef SIPO_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
  logic unused_par_fail;
  assign unused_par_fail = par_fail;
`endif

  sipo_hold #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .clear_n    (clear_n),
    .load       (load),
    .din        (shift_q),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overrun    (overrun)
  );

endmodule
